// File: rtl/tc_fetch_pkg.sv
// rtl/tc_fetch_pkg.sv - shared defaults and types for the fetch sequencer
package tc_fetch_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_PC_STEP    = 4;
   localparam int DEF_RESET_PC   = 0;

   typedef logic [31:0]               instr_word_t;
   typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/tc_fetch_perf.sv
// rtl/tc_fetch_perf.sv - accepted-transfer and stall-cycle counters (TC_FETCH_PERF_EN builds only)
module tc_fetch_perf
   import tc_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        accept,
   input  logic        stall,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
);

   // Free-running counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (accept) perf_fetched <= perf_fetched + 32'd1;
         if (stall)  perf_stalls  <= perf_stalls + 32'd1;
      end
   end

endmodule

// File: rtl/tc_fetch_sequencer.sv
// rtl/tc_fetch_sequencer.sv - PC owner and fetch pipeline in front of the decoder; optional TC_FETCH_PERF_EN counters
module tc_fetch_sequencer
   import tc_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    PC_STEP    = DEF_PC_STEP,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] pm_address,
   input  logic [7:0]            pm_out0,
   input  logic [7:0]            pm_out1,
   input  logic [7:0]            pm_out2,
   input  logic [7:0]            pm_out3,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output instr_word_t           instr_word,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  jump_valid,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic                  halt
`ifdef TC_FETCH_PERF_EN
   ,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_stalls
`endif
);

   logic                  inflight;
   logic [ADDR_WIDTH-1:0] inflight_pc;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  stall;
   logic                  issue;

   assign instr_valid = inflight;
   assign instr_pc    = inflight_pc;
   assign instr_word  = {pm_out3, pm_out2, pm_out1, pm_out0};

   assign stall = inflight & ~instr_ready;
   assign issue = jump_valid | (~stall & ~halt);

   // Address mux: a jump wins; a stall re-reads the presented word so the memory output stays put.
   always_comb begin
      pm_address = pc;
      if (jump_valid)
         pm_address = jump_target;
      else if (stall)
         pm_address = inflight_pc;
   end

   // Issue tracking: whatever address the memory samples becomes the next presented word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (issue) begin
         inflight    <= 1'b1;
         inflight_pc <= pm_address;
         pc          <= pm_address + ADDR_WIDTH'(PC_STEP);
      end else if (!stall) begin
         inflight    <= 1'b0;
      end
   end

`ifdef TC_FETCH_PERF_EN
   tc_fetch_perf u_perf (
      .clk          (clk),
      .rst          (rst),
      .accept       (inflight & instr_ready),
      .stall        (stall),
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls)
   );
`endif

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// tb/tb_tc_fetch_sequencer.sv - randomized self-checking bench for tc_fetch_sequencer (optional TC_FETCH_PERF_EN)
module tb_tc_fetch_sequencer;
   import tc_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pm_address;
   logic [7:0]  pm_out0, pm_out1, pm_out2, pm_out3;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_word;
   logic [15:0] instr_pc;
   logic        jump_valid;
   logic [15:0] jump_target;
   logic        halt;
`ifdef TC_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference state: what the decoder should currently see and where sequential fetch continues.
   logic        m_valid;
   logic [15:0] m_shown_pc;
   logic [15:0] m_next_pc;
   logic [31:0] m_fetched;
   logic [31:0] m_stalls;

   tc_fetch_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .pm_address  (pm_address),
      .pm_out0     (pm_out0),
      .pm_out1     (pm_out1),
      .pm_out2     (pm_out2),
      .pm_out3     (pm_out3),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_word  (instr_word),
      .instr_pc    (instr_pc),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .halt        (halt)
`ifdef TC_FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_stalls (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   // Program image: every address holds a distinct word derived from the address.
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      logic [15:0] hi;
      logic [15:0] lo;
      hi = a * 16'd7 + 16'd3;
      lo = a ^ 16'hC3A5;
      return {hi, lo};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid    = 1'b0;
      m_shown_pc = 16'h0000;
      m_next_pc  = 16'h0000;
      m_fetched  = 32'd0;
      m_stalls   = 32'd0;
   endtask

   // One clock: drive inputs after the falling edge, check, let the edge happen, then play memory.
   task automatic step(input logic jv, input logic [15:0] jt, input logic hl, input logic rdy);
      logic        stalled;
      logic        accepted;
      logic [15:0] want_addr;
      logic [15:0] seen_addr;
      jump_valid  = jv;
      jump_target = jt;
      halt        = hl;
      instr_ready = rdy;
      #1;
      accepted = m_valid && rdy;
      stalled  = m_valid && !rdy;
      if (jv)           want_addr = jt;
      else if (stalled) want_addr = m_shown_pc;
      else              want_addr = m_next_pc;
      check_eq("instr_valid", instr_valid, m_valid);
      check_eq("pm_address", pm_address, want_addr);
      if (m_valid) begin
         check_eq("instr_pc", instr_pc, m_shown_pc);
         check_eq("instr_word", instr_word, mem_word(m_shown_pc));
      end
`ifdef TC_FETCH_PERF_EN
      check_eq("perf_fetched", perf_fetched, m_fetched);
      check_eq("perf_stalls", perf_stalls, m_stalls);
`endif
      seen_addr = pm_address;
      if (accepted) m_fetched = m_fetched + 32'd1;
      if (stalled)  m_stalls  = m_stalls + 32'd1;
      if (jv || (!stalled && !hl)) begin
         m_valid    = 1'b1;
         m_shown_pc = want_addr;
         m_next_pc  = want_addr + 16'd4;
      end else if (!stalled) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      {pm_out3, pm_out2, pm_out1, pm_out0} = mem_word(seen_addr);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, instr_valid, 1'b0);
      check_eq({tag, "_pc"}, instr_pc, 16'h0000);
      check_eq({tag, "_addr"}, pm_address, 16'h0000);
`ifdef TC_FETCH_PERF_EN
      check_eq({tag, "_perf_fetched"}, perf_fetched, 32'd0);
      check_eq({tag, "_perf_stalls"}, perf_stalls, 32'd0);
`endif
   endtask

   initial begin
      logic        r_jv;
      logic [15:0] r_jt;
      logic        r_hl;
      logic        r_rdy;

      jump_valid  = 1'b0;
      jump_target = 16'h0000;
      halt        = 1'b0;
      instr_ready = 1'b1;
      {pm_out3, pm_out2, pm_out1, pm_out0} = 32'h0;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;

      // Straight-line fetch from RESET_PC.
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      // Back-pressure on the word at 4 for three cycles.
      repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      // Stall on 8, then redirect to 0x0100 while still stalled.
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b1, 16'h0100, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      // Address wrap past the top of the space.
      step(1'b1, 16'hFFFC, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      // Halt for two cycles, then resume sequentially.
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      // Unaligned target is used as-is.
      step(1'b1, 16'h0123, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a stream.
      jump_valid = 1'b0;
      halt       = 1'b0;
      rst        = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         r_jv  = ($urandom_range(0, 7) == 0);
         r_jt  = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                             : 16'($urandom);
         r_hl  = ($urandom_range(0, 5) == 0);
         r_rdy = ($urandom_range(0, 2) != 0);
         step(r_jv, r_jt, r_hl, r_rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
